maze_cell_arbiter: RTL and testbench

- Owns the maze cell store: 64x64 cells, 2 bits per cell (PATH=2'b11, FRONTIER=2'b10, WALL=2'b01, OUT=2'b00), one access per clock.
- Shares the store between three requesters:
  - carver: read/write.
  - display scan-out: read-only, latency-critical.
  - player/solver: read-only.
- Runs a clear sweep after reset and on request, so each new maze generation starts from an all-OUT store.

---
 rtl/maze_cell_if.sv | 54 +++++
 rtl/maze_cell_arbiter.sv | 126 ++++++++++++
 tb/tb_maze_cell_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_cell_if.sv
// Requester-side bundle for the maze cell store: carver (r/w), display and
// player (read-only) request/grant/read-data channels plus the clear control.
interface maze_cell_if #(
  parameter int X_BITS = 6,
  parameter int Y_BITS = 6
);
  logic              clear_req;
  logic              clear_busy;

  logic              cv_req;
  logic              cv_we;
  logic [X_BITS-1:0] cv_x;
  logic [Y_BITS-1:0] cv_y;
  logic [1:0]        cv_wdata;
  logic              cv_gnt;
  logic              cv_rvalid;
  logic [1:0]        cv_rdata;

  logic              dp_req;
  logic [X_BITS-1:0] dp_x;
  logic [Y_BITS-1:0] dp_y;
  logic              dp_gnt;
  logic              dp_rvalid;
  logic [1:0]        dp_rdata;

  logic              pl_req;
  logic [X_BITS-1:0] pl_x;
  logic [Y_BITS-1:0] pl_y;
  logic              pl_gnt;
  logic              pl_rvalid;
  logic [1:0]        pl_rdata;

  modport master (
    output clear_req,
    output cv_req, cv_we, cv_x, cv_y, cv_wdata,
    output dp_req, dp_x, dp_y,
    output pl_req, pl_x, pl_y,
    input  clear_busy,
    input  cv_gnt, cv_rvalid, cv_rdata,
    input  dp_gnt, dp_rvalid, dp_rdata,
    input  pl_gnt, pl_rvalid, pl_rdata
  );

  modport slave (
    input  clear_req,
    input  cv_req, cv_we, cv_x, cv_y, cv_wdata,
    input  dp_req, dp_x, dp_y,
    input  pl_req, pl_x, pl_y,
    output clear_busy,
    output cv_gnt, cv_rvalid, cv_rdata,
    output dp_gnt, dp_rvalid, dp_rdata,
    output pl_gnt, pl_rvalid, pl_rdata
  );
endinterface

// File: rtl/maze_cell_arbiter.sv
// Single-port maze cell store shared by carver, display and player, with a
// starvation-bounded display priority and a full clear sweep after reset.
module maze_cell_arbiter #(
  parameter int         X_BITS     = 6,
  parameter int         Y_BITS     = 6,
  parameter logic [1:0] CLEAR_VAL  = 2'b00,
  parameter int         STARVE_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  maze_cell_if.slave bus
);
  localparam int AW = X_BITS + Y_BITS;
  localparam int N  = 1 << AW;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] ST_MAX = SW'(STARVE_MAX);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_CV, SRC_DP, SRC_PL} src_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt;
  logic            rr_last;
  logic [SW-1:0]   cv_starve, pl_starve;
  src_e            win;

  logic [1:0]      mem [N];
  logic [AW-1:0]   mem_addr;
  logic            mem_we;
  logic [1:0]      mem_wdata;
  logic [1:0]      rd_q;
  logic [2:0]      rv_q;          // [0] carver, [1] display, [2] player
  logic [2:0][1:0] hold_q;

  logic cv_sat, pl_sat;
  assign cv_sat = bus.cv_req && (cv_starve == ST_MAX);
  assign pl_sat = bus.pl_req && (pl_starve == ST_MAX);

  // Sweep state machine
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (&cnt)         state_d = ST_RUN;
      ST_RUN:   if (bus.clear_req) state_d = ST_CLEAR;
      default:                    state_d = ST_CLEAR;
    endcase
  end

  // Starved carver/player beat display; rr_last=0 hands a tie to the player.
  always_comb begin
    win = SRC_NONE;
    if (state_q == ST_RUN) begin
      if (cv_sat && pl_sat)             win = rr_last ? SRC_CV : SRC_PL;
      else if (cv_sat)                  win = SRC_CV;
      else if (pl_sat)                  win = SRC_PL;
      else if (bus.dp_req)              win = SRC_DP;
      else if (bus.cv_req && bus.pl_req) win = rr_last ? SRC_CV : SRC_PL;
      else if (bus.cv_req)              win = SRC_CV;
      else if (bus.pl_req)              win = SRC_PL;
    end
  end

  always_comb begin
    mem_addr  = cnt;
    mem_we    = (state_q == ST_CLEAR) && reset;
    mem_wdata = CLEAR_VAL;
    case (win)
      SRC_CV: begin
        mem_addr  = {bus.cv_y, bus.cv_x};
        mem_we    = bus.cv_we;
        mem_wdata = bus.cv_wdata;
      end
      SRC_DP:  mem_addr = {bus.dp_y, bus.dp_x};
      SRC_PL:  mem_addr = {bus.pl_y, bus.pl_x};
      default: ;
    endcase
  end

  // Plain RAM, no reset, so it maps onto a block memory.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rd_q <= mem[mem_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      rr_last   <= 1'b0;
      cv_starve <= '0;
      pl_starve <= '0;
      rv_q      <= '0;
      hold_q    <= '0;
    end else begin
      cnt <= (state_q == ST_CLEAR) ? cnt + 1'b1 : '0;

      if (win == SRC_CV)      rr_last <= 1'b0;
      else if (win == SRC_PL) rr_last <= 1'b1;

      if (!bus.cv_req || win == SRC_CV) cv_starve <= '0;
      else if (cv_starve != ST_MAX)     cv_starve <= cv_starve + 1'b1;
      if (!bus.pl_req || win == SRC_PL) pl_starve <= '0;
      else if (pl_starve != ST_MAX)     pl_starve <= pl_starve + 1'b1;

      rv_q <= {win == SRC_PL, win == SRC_DP, (win == SRC_CV) && !bus.cv_we};
      for (int i = 0; i < 3; i++)
        if (rv_q[i]) hold_q[i] <= rd_q;
    end
  end

  assign bus.clear_busy = (state_q == ST_CLEAR);
  assign bus.cv_gnt     = (win == SRC_CV);
  assign bus.dp_gnt     = (win == SRC_DP);
  assign bus.pl_gnt     = (win == SRC_PL);
  assign bus.cv_rvalid  = rv_q[0];
  assign bus.dp_rvalid  = rv_q[1];
  assign bus.pl_rvalid  = rv_q[2];
  // Read data is live on the valid cycle and frozen otherwise.
  assign bus.cv_rdata   = rv_q[0] ? rd_q : hold_q[0];
  assign bus.dp_rdata   = rv_q[1] ? rd_q : hold_q[1];
  assign bus.pl_rdata   = rv_q[2] ? rd_q : hold_q[2];
endmodule

// File: tb/tb_maze_cell_arbiter.sv
// Directed steps plus a randomized phase, every cycle checked against a
// cell-array/priority-rule reference model of the arbiter.
module tb_maze_cell_arbiter;
  localparam int X_BITS = 6, Y_BITS = 6, N = 4096, STARVE_MAX = 15;
  localparam int CV = 1, DP = 2, PL = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  maze_cell_if #(.X_BITS(X_BITS), .Y_BITS(Y_BITS)) bus ();

  maze_cell_arbiter #(.X_BITS(X_BITS), .Y_BITS(Y_BITS), .CLEAR_VAL(2'b00),
                      .STARVE_MAX(STARVE_MAX))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int checks = 0, failures = 0;

  // reference model
  bit [1:0] cells [N];
  bit       m_busy;
  int       m_addr, m_cv_st, m_pl_st, m_win;
  bit       m_rr;
  bit [2:0] m_rv;
  bit [1:0] m_rd [3];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1; m_addr = 0; m_cv_st = 0; m_pl_st = 0; m_rr = 0; m_win = 0;
    m_rv = '0;
    for (int i = 0; i < 3; i++) m_rd[i] = 2'b00;
  endtask

  function automatic int pick();
    bit cv_h, pl_h;
    if (m_busy) return 0;
    cv_h = bus.cv_req && m_cv_st == STARVE_MAX;
    pl_h = bus.pl_req && m_pl_st == STARVE_MAX;
    if (cv_h && pl_h) return m_rr ? CV : PL;
    if (cv_h) return CV;
    if (pl_h) return PL;
    if (bus.dp_req) return DP;
    if (bus.cv_req && bus.pl_req) return m_rr ? CV : PL;
    if (bus.cv_req) return CV;
    if (bus.pl_req) return PL;
    return 0;
  endfunction

  // One clock: compare at the falling edge, then advance the model.
  task automatic cycle();
    int w;
    bit [2:0] nrv;
    @(negedge clk);
    w = pick();
    chk("clear_busy", 32'(bus.clear_busy), 32'(m_busy));
    chk("gnt", 32'({bus.cv_gnt, bus.dp_gnt, bus.pl_gnt}),
        32'({w == CV, w == DP, w == PL}));
    chk("rvalid", 32'({bus.pl_rvalid, bus.dp_rvalid, bus.cv_rvalid}), 32'(m_rv));
    chk("cv_rdata", 32'(bus.cv_rdata), 32'(m_rd[0]));
    chk("dp_rdata", 32'(bus.dp_rdata), 32'(m_rd[1]));
    chk("pl_rdata", 32'(bus.pl_rdata), 32'(m_rd[2]));
    nrv = '0;
    case (w)
      CV: if (bus.cv_we) cells[bus.cv_y * 64 + bus.cv_x] = bus.cv_wdata;
          else begin nrv[0] = 1; m_rd[0] = cells[bus.cv_y * 64 + bus.cv_x]; end
      DP: begin nrv[1] = 1; m_rd[1] = cells[bus.dp_y * 64 + bus.dp_x]; end
      PL: begin nrv[2] = 1; m_rd[2] = cells[bus.pl_y * 64 + bus.pl_x]; end
      default: ;
    endcase
    m_rv = nrv;
    if (w == CV) m_rr = 0;
    if (w == PL) m_rr = 1;
    m_cv_st = (!bus.cv_req || w == CV) ? 0 : (m_cv_st < STARVE_MAX ? m_cv_st + 1 : m_cv_st);
    m_pl_st = (!bus.pl_req || w == PL) ? 0 : (m_pl_st < STARVE_MAX ? m_pl_st + 1 : m_pl_st);
    if (m_busy) begin
      cells[m_addr] = 2'b00;
      if (m_addr == N - 1) begin m_busy = 0; m_addr = 0; end
      else m_addr++;
    end else if (bus.clear_req) begin
      m_busy = 1; m_addr = 0;
    end
    m_win = w;
    @(posedge clk);
    #1;
  endtask

  task automatic access(int who, bit we, int x, int y, bit [1:0] d);
    int n = 0;
    case (who)
      CV: begin bus.cv_req = 1; bus.cv_we = we; bus.cv_x = 6'(x); bus.cv_y = 6'(y); bus.cv_wdata = d; end
      DP: begin bus.dp_req = 1; bus.dp_x = 6'(x); bus.dp_y = 6'(y); end
      default: begin bus.pl_req = 1; bus.pl_x = 6'(x); bus.pl_y = 6'(y); end
    endcase
    do begin cycle(); n++; end while (m_win != who && n < 50);
    case (who)
      CV: bus.cv_req = 0;
      DP: bus.dp_req = 0;
      default: bus.pl_req = 0;
    endcase
  endtask

  // Counts sweep cycles; optionally pulses clear_req when the count hits pulse_at.
  task automatic sweep_len(int pulse_at, output int n);
    n = 0;
    while (bus.clear_busy === 1'b1 && n < 5000) begin
      bus.clear_req = (n == pulse_at);
      cycle();
      n++;
    end
    bus.clear_req = 0;
  endtask

  function automatic int rc();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    int n;
    reset = 0;
    bus.clear_req = 0;
    bus.cv_req = 1; bus.cv_we = 0; bus.cv_x = 0; bus.cv_y = 0; bus.cv_wdata = 0;
    bus.dp_req = 1; bus.dp_x = 0; bus.dp_y = 0;
    bus.pl_req = 1; bus.pl_x = 0; bus.pl_y = 0;
    for (int i = 0; i < N; i++) cells[i] = 2'b00;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.clear_busy), 1);
    chk("rst_gnt", 32'({bus.cv_gnt, bus.dp_gnt, bus.pl_gnt}), 0);
    chk("rst_rvalid", 32'({bus.cv_rvalid, bus.dp_rvalid, bus.pl_rvalid}), 0);
    chk("rst_rdata", 32'({bus.cv_rdata, bus.dp_rdata, bus.pl_rdata}), 0);
    reset = 1;

    // 1: sweep with all requests pending, then display corner reads
    sweep_len(-1, n);
    chk("sweep_len", 32'(n), 4096);
    bus.cv_req = 0; bus.dp_req = 0; bus.pl_req = 0;
    access(DP, 0, 0, 0, 0);
    chk("dp_rv_00", 32'(bus.dp_rvalid), 1);
    chk("dp_rd_00", 32'(bus.dp_rdata), 0);
    access(DP, 0, 63, 63, 0);
    chk("dp_rv_6363", 32'(bus.dp_rvalid), 1);
    chk("dp_rd_6363", 32'(bus.dp_rdata), 0);

    // 2: write then read-back of the same cell
    access(CV, 1, 5, 7, 2'b11);
    chk("cv_wr_norv", 32'(bus.cv_rvalid), 0);
    access(CV, 0, 5, 7, 0);
    chk("cv_rd_rv", 32'(bus.cv_rvalid), 1);
    chk("cv_rd_data", 32'(bus.cv_rdata), 3);

    // 3: carver vs player alternate, player first
    bus.cv_req = 1; bus.cv_we = 0; bus.pl_req = 1;
    #1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_alt", 32'({bus.cv_gnt, bus.pl_gnt}), (i % 2) ? 2 : 1);
      cycle();
    end
    bus.cv_req = 0; bus.pl_req = 0;
    cycle();

    // 4: display hogging, carver breaks through on the 16th cycle
    bus.dp_req = 1; bus.dp_x = 1; bus.dp_y = 2;
    bus.cv_req = 1; bus.cv_we = 0; bus.cv_x = 5; bus.cv_y = 7;
    #1;
    for (int i = 1; i <= 16; i++) begin
      chk("starve_cv", 32'(bus.cv_gnt), 32'(i == 16));
      chk("starve_dp", 32'(bus.dp_gnt), 32'(i != 16));
      cycle();
    end
    chk("dp_regain", 32'({bus.dp_gnt, bus.cv_gnt}), 2);
    bus.cv_req = 0; bus.dp_req = 0;
    cycle();

    // 5: re-clear with an ignored second pulse mid-sweep
    access(CV, 1, 10, 20, 2'b11);
    bus.clear_req = 1;
    cycle();
    bus.clear_req = 0;
    sweep_len(100, n);
    chk("clear_len", 32'(n), 4096);
    access(PL, 0, 10, 20, 0);
    chk("clear_rv", 32'(bus.pl_rvalid), 1);
    chk("clear_rd", 32'(bus.pl_rdata), 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if (!bus.cv_req || m_win == CV) begin
        bus.cv_req = ($urandom_range(0, 99) < 45);
        bus.cv_we = 1'($urandom_range(0, 1)); bus.cv_wdata = 2'($urandom_range(0, 3));
        bus.cv_x = 6'(rc()); bus.cv_y = 6'(rc());
      end else if ($urandom_range(0, 99) < 3) bus.cv_req = 0;
      if (!bus.dp_req || m_win == DP) begin
        bus.dp_req = ($urandom_range(0, 99) < ((c < 1500) ? 95 : 50));
        bus.dp_x = 6'(rc()); bus.dp_y = 6'(rc());
      end else if ($urandom_range(0, 99) < 3) bus.dp_req = 0;
      if (!bus.pl_req || m_win == PL) begin
        bus.pl_req = ($urandom_range(0, 99) < 45);
        bus.pl_x = 6'(rc()); bus.pl_y = 6'(rc());
      end else if ($urandom_range(0, 99) < 3) bus.pl_req = 0;
      cycle();
    end
    bus.cv_req = 0; bus.dp_req = 0; bus.pl_req = 0;
    cycle();
    access(CV, 1, 1, 1, 2'b11);
    access(DP, 0, 1, 1, 0);
    access(PL, 0, 1, 1, 0);
    access(CV, 0, 1, 1, 0);
    cycle();

    // 6: reset in the middle of a sweep
    bus.clear_req = 1;
    cycle();
    bus.clear_req = 0;
    n = 0;
    while (bus.clear_busy === 1'b1 && n < 2000) begin cycle(); n++; end
    reset = 0;
    #1;
    chk("mid_rst_busy", 32'(bus.clear_busy), 1);
    chk("mid_rst_rvalid", 32'({bus.cv_rvalid, bus.dp_rvalid, bus.pl_rvalid}), 0);
    chk("mid_rst_rdata", 32'({bus.cv_rdata, bus.dp_rdata, bus.pl_rdata}), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    sweep_len(-1, n);
    chk("rst_sweep_len", 32'(n), 4096);
    access(DP, 0, 1, 1, 0);
    chk("post_rst_rd", 32'(bus.dp_rdata), 0);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
